// File: rtl/icache_sa_if.sv
// icache_sa_if: CPU fetch port, refill port and flush status of the set-associative icache
interface icache_sa_if #(parameter int LINE_BITS = 256);
  logic [31:0]          mem_address;
  logic                 mem_read;
  logic                 flush;
  logic [31:0]          mem_rdata;
  logic                 mem_resp;
  logic [31:0]          pmem_address;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_read;
  logic                 pmem_resp;
  logic                 flush_busy;
  modport master (
    output mem_address, mem_read, flush, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, flush_busy
  );
  modport slave (
    input  mem_address, mem_read, flush, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, flush_busy
  );
endinterface

// File: rtl/icache_sa.sv
// icache_sa: set-associative read-only instruction cache, tree-PLRU replacement, single-cycle flush
module icache_sa #(
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 2,
  parameter int LINE_BITS = 256
) (
  input logic        clk,
  input logic        rst_n,
  icache_sa_if.slave bus
);
  localparam int OB = $clog2(LINE_BITS / 8);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 32 - OB - IB;
  localparam int SB = OB - 2;
  localparam int LW = $clog2(NUM_WAYS);
  localparam int WB = LW > 0 ? LW : 1;
  localparam int PW = NUM_WAYS > 1 ? NUM_WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t               state, state_n;
  logic [NUM_WAYS-1:0]  valid [NUM_SETS];
  logic [TB-1:0]        tags  [NUM_SETS][NUM_WAYS];
  logic [PW-1:0]        plru  [NUM_SETS];
  logic [LINE_BITS-1:0] data  [NUM_SETS][NUM_WAYS];
  logic                 pend, hit, resp;
  logic [WB-1:0]        hit_way, victim, victim_n;
  logic [IB-1:0]        idx;
  logic [TB-1:0]        tag;
  logic [SB-1:0]        wsel;
  logic                 unused;

  assign idx    = bus.mem_address[OB+IB-1:OB];
  assign tag    = bus.mem_address[31:OB+IB];
  assign wsel   = bus.mem_address[OB-1:2];
  assign unused = ^bus.mem_address[1:0];

  // Heap-ordered tree: node n (1-based) lives in bit n-1; a bit points toward the LRU half.
  function automatic logic [WB-1:0] plru_victim(input logic [PW-1:0] p);
    int n = 1;
    for (int l = 0; l < LW; l++) n = 2 * n + (p[n-1] ? 1 : 0);
    return WB'(n - NUM_WAYS);
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WB-1:0] w);
    logic [PW-1:0] r = p;
    int leaf = NUM_WAYS + int'(w);
    int n;
    for (int l = 0; l < LW; l++) begin
      n = leaf >> (LW - l);
      r[n-1] = ((leaf >> (LW - 1 - l)) & 1) == 0;
    end
    return r;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    victim_n = plru_victim(plru[idx]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) if (!valid[idx][w]) victim_n = WB'(w);
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
  end

  assign resp             = state == IDLE && bus.mem_read && hit && !bus.flush;
  assign bus.mem_resp     = resp;
  assign bus.mem_rdata    = data[idx][hit_way][{wsel, 5'd0} +: 32];
  assign bus.pmem_read    = state == FETCH;
  assign bus.pmem_address = state == FETCH ? {bus.mem_address[31:OB], {OB{1'b0}}} : '0;
  assign bus.flush_busy   = pend || state == FLUSH;

  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = bus.flush ? FLUSH : (bus.mem_read && !hit) ? FETCH : IDLE;
    else if (state == FETCH)
      state_n = !bus.pmem_resp ? FETCH : (pend || bus.flush) ? FLUSH : IDLE;
    else
      state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= 1'b0;
      victim <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
        for (int w = 0; w < NUM_WAYS; w++) tags[s][w] <= '0;
      end
    end else begin
      state <= state_n;
      pend  <= state == FETCH && !bus.pmem_resp && (pend || bus.flush);
      if (state == IDLE && bus.mem_read && !hit && !bus.flush) victim <= victim_n;
      if (state == FLUSH)
        for (int s = 0; s < NUM_SETS; s++) begin
          valid[s] <= '0;
          plru[s]  <= '0;
        end
      else if (state == FETCH && bus.pmem_resp) begin
        valid[idx][victim] <= 1'b1;
        tags[idx][victim]  <= tag;
        plru[idx]          <= plru_touch(plru[idx], victim);
      end else if (resp)
        plru[idx] <= plru_touch(plru[idx], hit_way);
    end

  always_ff @(posedge clk)
    if (state == FETCH && bus.pmem_resp) data[idx][victim] <= bus.pmem_rdata;
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed checks of a 2-way 8-set cache and a direct-mapped 4-set cache
module tb_icache_sa;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic [31:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         flush = 1'b0;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         o_resp, o_pread, o_busy;
  logic [31:0]  o_rdata, o_paddr;
  int           tests = 0;
  int           fails = 0;
  int           r_cyc, r_refills, r_flc;
  logic         r_done, r_busyf;
  logic [31:0]  r_data, r_addr;

  always #5 clk = ~clk;

  icache_sa_if #(.LINE_BITS(256)) a ();
  icache_sa_if #(.LINE_BITS(256)) b ();

  icache_sa #(.NUM_SETS(8), .NUM_WAYS(2), .LINE_BITS(256)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  icache_sa #(.NUM_SETS(4), .NUM_WAYS(1), .LINE_BITS(256)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  assign a.mem_address = mem_address;
  assign a.mem_read    = mem_read & ~sel;
  assign a.flush       = flush & ~sel;
  assign a.pmem_rdata  = pmem_rdata;
  assign a.pmem_resp   = pmem_resp & ~sel;
  assign b.mem_address = mem_address;
  assign b.mem_read    = mem_read & sel;
  assign b.flush       = flush & sel;
  assign b.pmem_rdata  = pmem_rdata;
  assign b.pmem_resp   = pmem_resp & sel;
  assign o_resp  = sel ? b.mem_resp : a.mem_resp;
  assign o_rdata = sel ? b.mem_rdata : a.mem_rdata;
  assign o_pread = sel ? b.pmem_read : a.pmem_read;
  assign o_paddr = sel ? b.pmem_address : a.pmem_address;
  assign o_busy  = sel ? b.flush_busy : a.flush_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word i of a line holds 0xC0DE0000 | (line address + 4*i).
  function automatic logic [255:0] line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC0DE_0000 | (la + 32'(4 * i));
    return l;
  endfunction

  // fl: -1 none, 0 flush with the request, k>0 flush in k-th cycle of the first refill
  task automatic rd(input logic [31:0] addr, input int lat, input int fl);
    int fetch = 0;
    r_cyc = 0; r_refills = 0; r_flc = 0; r_done = 0; r_busyf = 0; r_data = '0; r_addr = '0;
    @(posedge clk); #1;
    mem_address = addr;
    mem_read = 1'b1;
    flush = fl == 0;
    while (!r_done && r_cyc < 60) begin
      @(negedge clk);
      r_cyc++;
      if (o_resp) begin
        r_done = 1'b1;
        r_data = o_rdata;
      end
      if (o_pread) begin
        fetch++;
        if (fetch == 1 && r_refills == 0) r_addr = o_paddr;
        if (o_busy) r_busyf = 1'b1;
        if (fl > 0 && r_refills == 0 && fetch == fl) flush = 1'b1;
        if (fetch == lat) begin
          pmem_resp = 1'b1;
          pmem_rdata = line(o_paddr);
          r_refills++;
        end
      end else begin
        fetch = 0;
        if (o_busy) r_flc++;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input int cyc, input int refills, input logic [31:0] d);
    check({tag, ".done"}, 32'(r_done), 32'd1);
    check({tag, ".cyc"}, 32'(r_cyc), 32'(cyc));
    check({tag, ".refills"}, 32'(r_refills), 32'(refills));
    check({tag, ".data"}, r_data, d);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.resp", 32'(o_resp), 0);
    check("rst.pread", 32'(o_pread), 0);
    check("rst.paddr", o_paddr, 0);
    check("rst.busy", 32'(o_busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    rd(32'h0000_0104, 3, -1);
    expect_rd("cold104", 5, 1, 32'hC0DE_0104);
    check("cold104.paddr", r_addr, 32'h0000_0100);
    rd(32'h0000_0108, 3, -1);
    expect_rd("hit108", 1, 0, 32'hC0DE_0108);
    @(negedge clk);
    check("idle.paddr", o_paddr, 0);
    check("idle.pread", 32'(o_pread), 0);

    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk); check("fl_idle.resp", 32'(o_resp), 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); check("fl_idle.busy", 32'(o_busy), 1);
    @(negedge clk); check("fl_idle.busy_end", 32'(o_busy), 0);
    rd(32'h0000_0108, 3, -1);
    expect_rd("postflush108", 5, 1, 32'hC0DE_0108);

    rd(32'h0000_0000, 2, -1);
    expect_rd("fill000", 4, 1, 32'hC0DE_0000);
    rd(32'h0000_0004, 3, -1);
    expect_rd("touch000", 1, 0, 32'hC0DE_0004);
    rd(32'h0000_0200, 3, -1);
    expect_rd("fill200", 5, 1, 32'hC0DE_0200);
    rd(32'h0000_0008, 3, -1);
    expect_rd("keep000", 1, 0, 32'hC0DE_0008);
    rd(32'h0000_010C, 3, -1);
    expect_rd("evict100", 5, 1, 32'hC0DE_010C);

    rd(32'h0000_0000, 3, 0);
    expect_rd("flush_hit", 7, 1, 32'hC0DE_0000);
    check("flush_hit.flc", 32'(r_flc), 1);

    rd(32'h0000_0040, 4, 2);
    expect_rd("flush_fetch", 12, 2, 32'hC0DE_0040);
    check("flush_fetch.busy", 32'(r_busyf), 1);
    check("flush_fetch.flc", 32'(r_flc), 1);
    check("flush_fetch.paddr", r_addr, 32'h0000_0040);
    rd(32'h0000_0044, 3, -1);
    expect_rd("after_ff", 1, 0, 32'hC0DE_0044);

    @(posedge clk); #1;
    mem_address = 32'h0000_0300;
    mem_read = 1'b1;
    @(negedge clk); check("rstf.c1_pread", 32'(o_pread), 0);
    @(negedge clk); check("rstf.pread", 32'(o_pread), 1);
    check("rstf.paddr", o_paddr, 32'h0000_0300);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("rstf.pread_drop", 32'(o_pread), 0);
    check("rstf.paddr_drop", o_paddr, 0);
    check("rstf.busy", 32'(o_busy), 0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = line(32'h0000_0300);
    @(negedge clk);
    check("late.resp", 32'(o_resp), 0);
    check("late.pread", 32'(o_pread), 0);
    @(posedge clk); #1 pmem_resp = 1'b0;
    rd(32'h0000_0300, 3, -1);
    expect_rd("cold300", 5, 1, 32'hC0DE_0300);
    rd(32'h0000_0000, 3, -1);
    expect_rd("cold000", 5, 1, 32'hC0DE_0000);

    sel = 1'b1;
    rd(32'h0000_0000, 3, -1);
    expect_rd("dm000", 5, 1, 32'hC0DE_0000);
    rd(32'h0000_0080, 3, -1);
    expect_rd("dm080", 5, 1, 32'hC0DE_0080);
    rd(32'h0000_0004, 3, -1);
    expect_rd("dm004", 5, 1, 32'hC0DE_0004);
    rd(32'h0000_0084, 3, -1);
    expect_rd("dm084", 5, 1, 32'hC0DE_0084);
    rd(32'h0000_0088, 3, -1);
    expect_rd("dm088", 1, 0, 32'hC0DE_0088);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
